sad_min_tracker: RTL and testbench

Downstream consumer of one row of the motion-estimation PE array. Each valid cycle it takes the NUM_PE absolute differences produced by the PEs and sums them in a registered adder tree. It accumulates ROWS such sums into one candidate SAD, then compares successive candidate SADs to keep the minimum SAD and its candidate index. When NUM_CAND candidates have been processed, it pulses done and holds the result for the motion-vector decision stage.

---
 rtl/sad_min_tracker.sv | 212 +++++++++++++++++++++
 tb/tb_sad_min_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: sums one row of PE absolute differences per valid beat,
// accumulates ROWS beats into a candidate SAD and tracks the minimum SAD and
// the index of the candidate that produced it over NUM_CAND candidates.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse, begins a search (only honoured in IDLE)
//   abs_valid abs_in carries one row beat this cycle
//   abs_in    packed PE abs values, PE i at [i*PIXEL +: PIXEL]
//   busy      high while a search is running or draining
//   done      one-cycle pulse when best_* are final
//   best_sad  minimum candidate SAD so far
//   best_idx  index of the candidate that produced best_sad
module sad_min_tracker #(
  parameter int unsigned PIXEL    = 8,
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned NUM_CAND = 64,
  localparam int unsigned CAND_W  = $clog2(NUM_CAND),
  localparam int unsigned SAD_W   = PIXEL + $clog2(NUM_PE) + $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abs_valid,
  input  logic [NUM_PE*PIXEL-1:0] abs_in,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic [CAND_W-1:0]       best_idx
);

  localparam int unsigned IN_W   = NUM_PE * PIXEL;
  localparam int unsigned TREE_W = PIXEL + $clog2(NUM_PE);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned TOT_W  = CAND_W + ROW_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Stage 0: input capture
  logic              in_v_q, in_v_d;
  logic [IN_W-1:0]   in_data_q, in_data_d;
  logic [TOT_W-1:0]  in_cnt_q, in_cnt_d;
  // Stage 1: adder tree
  logic              tree_v_q, tree_v_d;
  logic [TREE_W-1:0] tree_q, tree_d;
  logic [TREE_W-1:0] tree_sum_c;
  // Stage 2: row accumulation
  logic [SAD_W-1:0]  acc_q, acc_d;
  logic [ROW_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CAND_W-1:0] cand_cnt_q, cand_cnt_d;
  logic              cand_v_q, cand_v_d;
  logic [SAD_W-1:0]  cand_sad_q, cand_sad_d;
  logic [CAND_W-1:0] cand_idx_q, cand_idx_d;
  // Stage 3: running minimum
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [CAND_W-1:0] best_idx_q, best_idx_d;

  logic accept_c;
  logic start_ok_c;
  logic last_beat_c;
  logic last_cand_c;
  logic [SAD_W-1:0] acc_sum_c;

  assign accept_c    = (state_q == S_RUN) && abs_valid;
  assign start_ok_c  = (state_q == S_IDLE) && start;
  // The total-beat counter is all ones on the final beat of the search.
  assign last_beat_c = accept_c && (&in_cnt_q);
  assign last_cand_c = cand_v_q && (cand_idx_q == CAND_W'(NUM_CAND - 1));
  assign acc_sum_c   = acc_q + SAD_W'(tree_q);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)       state_d = S_RUN;
      S_RUN:   if (last_beat_c) state_d = S_FLUSH;
      S_FLUSH: if (last_cand_c) state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM outputs, registered from the next state so they align with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_RUN, S_FLUSH: busy_d = 1'b1;
      S_DONE:         done_d = 1'b1;
      default:        ;
    endcase
  end

  // Adder tree over the captured PE row
  always_comb begin
    tree_sum_c = '0;
    for (int i = 0; i < int'(NUM_PE); i++) begin
      tree_sum_c = tree_sum_c + TREE_W'(in_data_q[i*PIXEL +: PIXEL]);
    end
  end

  // Datapath next state
  always_comb begin
    in_v_d     = accept_c;
    in_data_d  = accept_c ? abs_in : in_data_q;
    in_cnt_d   = accept_c ? in_cnt_q + TOT_W'(1) : in_cnt_q;

    tree_v_d   = in_v_q;
    tree_d     = in_v_q ? tree_sum_c : tree_q;

    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    cand_cnt_d = cand_cnt_q;
    cand_v_d   = 1'b0;
    cand_sad_d = cand_sad_q;
    cand_idx_d = cand_idx_q;
    if (tree_v_q) begin
      beat_cnt_d = beat_cnt_q + ROW_W'(1);
      if (beat_cnt_q == ROW_W'(ROWS - 1)) begin
        cand_v_d   = 1'b1;
        cand_sad_d = acc_sum_c;
        cand_idx_d = cand_cnt_q;
        cand_cnt_d = cand_cnt_q + CAND_W'(1);
        acc_d      = '0;
      end else begin
        acc_d      = acc_sum_c;
      end
    end

    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    // Strict compare keeps the earlier index on ties.
    if (cand_v_q && (cand_sad_q < best_sad_q)) begin
      best_sad_d = cand_sad_q;
      best_idx_d = cand_idx_q;
    end

    // An accepted start discards any previous result and pipeline content.
    if (start_ok_c) begin
      in_v_d     = 1'b0;
      in_cnt_d   = '0;
      tree_v_d   = 1'b0;
      acc_d      = '0;
      beat_cnt_d = '0;
      cand_cnt_d = '0;
      cand_v_d   = 1'b0;
      best_sad_d = '1;
      best_idx_d = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_v_q     <= 1'b0;
      in_data_q  <= '0;
      in_cnt_q   <= '0;
      tree_v_q   <= 1'b0;
      tree_q     <= '0;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      cand_cnt_q <= '0;
      cand_v_q   <= 1'b0;
      cand_sad_q <= '0;
      cand_idx_q <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_v_q     <= in_v_d;
      in_data_q  <= in_data_d;
      in_cnt_q   <= in_cnt_d;
      tree_v_q   <= tree_v_d;
      tree_q     <= tree_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      cand_v_q   <= cand_v_d;
      cand_sad_q <= cand_sad_d;
      cand_idx_q <= cand_idx_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Testbench for sad_min_tracker: directed searches against a transaction-level
// model (per-candidate sums, argmin, fixed drain latency) checked every cycle,
// plus literal expectations for each scenario.
module tb_sad_min_tracker;

  localparam int PIXEL    = 8;
  localparam int NUM_PE   = 8;
  localparam int ROWS     = 8;
  localparam int NUM_CAND = 64;
  localparam int CAND_W   = 6;
  localparam int SAD_W    = 14;
  localparam int BEATS    = NUM_CAND * ROWS;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    abs_valid;
  logic [NUM_PE*PIXEL-1:0] abs_in;
  logic                    busy;
  logic                    done;
  logic [SAD_W-1:0]        best_sad;
  logic [CAND_W-1:0]       best_idx;

  sad_min_tracker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abs_valid(abs_valid),
    .abs_in   (abs_in),
    .busy     (busy),
    .done     (done),
    .best_sad (best_sad),
    .best_idx (best_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int at;
    int sad;
    int idx;
  } upd_t;

  upd_t pend[$];
  upd_t u;
  int   cyc      = 0;
  int   last_cyc = -100;
  int   m_beats  = 0;
  int   m_sum    = 0;
  int   m_best   = 16383;
  int   m_idx    = 0;
  bit   m_busy   = 1'b0;
  bit   m_acc_on = 1'b0;
  bit   m_done   = 1'b0;
  bit   prev_done;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_acc_on = 0; m_done = 0; m_beats = 0; m_sum = 0;
      m_best = 16383; m_idx = 0; last_cyc = -100;
      pend.delete();
    end else begin
      cyc++;
      prev_done = m_done;
      m_done = 0;
      if (!m_busy && !prev_done && start) begin
        m_busy = 1; m_acc_on = 1; m_beats = 0; m_sum = 0;
        m_best = 16383; m_idx = 0;
        pend.delete();
      end else if (m_acc_on && abs_valid) begin
        for (int p = 0; p < NUM_PE; p++) m_sum += int'(abs_in[p*PIXEL +: PIXEL]);
        m_beats++;
        if (m_beats % ROWS == 0) begin
          pend.push_back('{at: cyc + 3, sad: m_sum, idx: m_beats / ROWS - 1});
          m_sum = 0;
        end
        if (m_beats == BEATS) begin
          m_acc_on = 0;
          last_cyc = cyc;
        end
      end
      while (pend.size() > 0 && pend[0].at == cyc) begin
        u = pend.pop_front();
        if (u.sad < m_best) begin
          m_best = u.sad;
          m_idx  = u.idx;
        end
      end
      if (m_busy && !m_acc_on && cyc == last_cyc + 3) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("best_sad", 32'(best_sad), 32'(m_best));
      chk("best_idx", 32'(best_idx), 32'(m_idx));
      if (done) begin
        done_cnt++;
        // done occupies the fourth cycle following the last beat's edge
        chk("done_latency", 32'(cyc - last_cyc), 32'd3);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int pat(input int mode, input int cand);
    case (mode)
      0:       return (cand == 20) ? 1 : 2;
      1:       return (cand == 5 || cand == 9) ? 0 : 3;
      default: return 255;
    endcase
  endfunction

  function automatic logic [NUM_PE*PIXEL-1:0] pack(input int v);
    logic [NUM_PE*PIXEL-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_PE; p++) r[p*PIXEL +: PIXEL] = PIXEL'(v);
    return r;
  endfunction

  // Runs one search; stop_after >= 0 abandons it after that many beats.
  task automatic run_search(input int mode, input bit bubbles, input bit ctl, input int stop_after);
    bit seen;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (stop_after >= 0 && b == stop_after) return;
      while (bubbles && $urandom_range(0, 1) == 0) begin
        abs_valid = 1'b0;
        abs_in    = pack(7);
        @(negedge clk);
      end
      abs_valid = 1'b1;
      abs_in    = pack(pat(mode, b / ROWS));
      start     = ctl && (b == 100);
      @(negedge clk);
    end
    abs_valid = 1'b0;
    start     = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_timeout", 32'(seen), 32'd1);
    if (ctl) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_result(input string name, input int sad, input int idx);
    chk({name, "_sad"}, 32'(best_sad), 32'(sad));
    chk({name, "_idx"}, 32'(best_idx), 32'(idx));
    chk({name, "_model_sad"}, 32'(m_best), 32'(sad));
    chk({name, "_model_idx"}, 32'(m_idx), 32'(idx));
  endtask

  initial begin
    start = 1'b0; abs_valid = 1'b0; abs_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sad", 32'(best_sad), 32'd16383);
    chk("rst_idx", 32'(best_idx), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_search(0, 1'b0, 1'b0, -1);
    check_result("unique", 64, 20);

    run_search(1, 1'b0, 1'b0, -1);
    check_result("tie", 0, 5);

    // start pulses during RUN and in the DONE cycle must be ignored
    run_search(2, 1'b0, 1'b1, -1);
    check_result("saturate", 16320, 0);

    // beats in IDLE change nothing
    abs_valid = 1'b1;
    abs_in    = pack(0);
    repeat (6) @(negedge clk);
    abs_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    check_result("idle_beats", 16320, 0);

    run_search(0, 1'b1, 1'b0, -1);
    check_result("bubbles", 64, 20);

    // reset in the middle of a search
    run_search(0, 1'b0, 1'b0, 200);
    abs_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sad", 32'(best_sad), 32'd16383);
    chk("midrst_idx", 32'(best_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_search(1, 1'b1, 1'b0, -1);
    check_result("post_rst", 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
